// File: rtl/mdu_if.sv
// Decoder/E-stage bus of the multiply/divide unit: op, operands, exception request,
// and the busy/HI/LO/read-back results returned to the pipeline.
interface mdu_if;
  logic [3:0]  MDUop;
  logic        MDUstart;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic [31:0] MDUout;

  modport master (
    output MDUop, MDUstart, A, B, req,
    input  busy, HI_out, LO_out, MDUout
  );

  modport slave (
    input  MDUop, MDUstart, A, B, req,
    output busy, HI_out, LO_out, MDUout
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO; the result is computed at the
// start edge, parked in pending registers, and committed when the busy countdown expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] cycles_s;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      pend_hi_r;
  logic [31:0]      pend_lo_r;
  logic             pend_ok_r;
  logic [0:0]       state_s;
  logic             start_s;
  logic             move_s;

  logic             a_neg_s;
  logic             b_neg_s;
  logic [31:0]      div_a_s;
  logic [31:0]      div_b_s;
  logic [31:0]      q_mag_s;
  logic [31:0]      r_mag_s;
  logic [63:0]      prod_s;
  logic [31:0]      res_hi_s;
  logic [31:0]      res_lo_s;
  logic             res_ok_s;

  assign state_s = (count_r == CNT_ZERO) ? ST_IDLE : ST_CALC;

  // Decide whether this edge launches a calculation or a move-to-HI/LO.
  always_comb begin
    start_s  = 1'b0;
    move_s   = 1'b0;
    cycles_s = CNT_ZERO;
    if ((state_s == ST_IDLE) && !bus.req) begin
      case (bus.MDUop)
        OP_MULT, OP_MULTU: begin
          start_s  = bus.MDUstart;
          cycles_s = CNT_MULT;
        end
        OP_DIV, OP_DIVU: begin
          start_s  = bus.MDUstart;
          cycles_s = CNT_DIV;
        end
        OP_MTHI, OP_MTLO: begin
          move_s = 1'b1;
        end
        default: begin
          start_s = 1'b0;
        end
      endcase
    end else begin
      start_s = 1'b0;
      move_s  = 1'b0;
    end
  end

  // Countdown next value: load on start, otherwise run down to zero.
  always_comb begin
    count_nxt_s = count_r;
    if (start_s) begin
      count_nxt_s = cycles_s;
    end else if (count_r != CNT_ZERO) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = CNT_ZERO;
    end
  end

  // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    a_neg_s = (bus.MDUop == OP_DIV) && bus.A[31];
    b_neg_s = (bus.MDUop == OP_DIV) && bus.B[31];
    div_a_s = a_neg_s ? (~bus.A + 32'd1) : bus.A;
    div_b_s = b_neg_s ? (~bus.B + 32'd1) : bus.B;
    if (bus.B == 32'd0) begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end else begin
      q_mag_s = div_a_s / div_b_s;
      r_mag_s = div_a_s % div_b_s;
    end
  end

  // Select the 64-bit result and whether it may be committed.
  always_comb begin
    prod_s   = 64'd0;
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    res_ok_s = 1'b0;
    case (bus.MDUop)
      OP_MULT: begin
        prod_s   = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
        res_ok_s = 1'b1;
      end
      OP_MULTU: begin
        prod_s   = {32'd0, bus.A} * {32'd0, bus.B};
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
        res_ok_s = 1'b1;
      end
      OP_DIV: begin
        res_lo_s = (a_neg_s ^ b_neg_s) ? (~q_mag_s + 32'd1) : q_mag_s;
        res_hi_s = a_neg_s ? (~r_mag_s + 32'd1) : r_mag_s;
        res_ok_s = (bus.B != 32'd0);
      end
      OP_DIVU: begin
        res_lo_s = q_mag_s;
        res_hi_s = r_mag_s;
        res_ok_s = (bus.B != 32'd0);
      end
      default: begin
        res_ok_s = 1'b0;
      end
    endcase
  end

  // State, pending result, and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r   <= CNT_ZERO;
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_ok_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      busy_r  <= (count_nxt_s != CNT_ZERO);
      if (start_s) begin
        pend_hi_r <= res_hi_s;
        pend_lo_r <= res_lo_s;
        pend_ok_r <= res_ok_s;
      end
      if ((state_s == ST_CALC) && (count_r == CNT_ONE)) begin
        if (pend_ok_r) begin
          hi_r <= pend_hi_r;
          lo_r <= pend_lo_r;
        end
      end else if (move_s) begin
        if (bus.MDUop == OP_MTHI) begin
          hi_r <= bus.A;
        end else begin
          lo_r <= bus.A;
        end
      end
    end
  end

  // mfhi/mflo read-back; stale while busy by design.
  always_comb begin
    case (bus.MDUop)
      OP_MFHI: bus.MDUout = hi_r;
      OP_MFLO: bus.MDUout = lo_r;
      default: bus.MDUout = 32'd0;
    endcase
  end

  assign bus.busy   = busy_r;
  assign bus.HI_out = hi_r;
  assign bus.LO_out = lo_r;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: hand-computed HI/LO/busy expectations checked with
// immediate assertions.
`timescale 1ns/1ps
module tb_mdu_unit;
  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   cnt;

  mdu_if bus();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MDUop    = 4'd0;
    bus.MDUstart = 1'b0;
    bus.req      = 1'b0;
  endtask

  // Issue a start pulse, then measure how many sampled cycles busy stays high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rq, input string tag, input int exp_len);
    bus.MDUop    = op;
    bus.MDUstart = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.req      = rq;
    cyc();
    idle();
    cnt = 0;
    while (bus.busy && cnt < 64) begin
      cnt++;
      cyc();
    end
    chk(tag, 32'(cnt), 32'(exp_len));
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] a, input logic rq);
    bus.MDUop = op;
    bus.A     = a;
    bus.req   = rq;
    cyc();
    idle();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    bus.A  = 32'd0;
    bus.B  = 32'd0;
    idle();
    repeat (2) cyc();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.HI_out, 32'd0);
    chk("reset_lo", bus.LO_out, 32'd0);
    chk("reset_mduout", bus.MDUout, 32'd0);
    reset = 1'b1;
    cyc();

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, "mult_busy_len", 5);
    chk("mult_hi", bus.HI_out, 32'hFFFFFFFF);
    chk("mult_lo", bus.LO_out, 32'hFFFFFFFA);
    bus.MDUop = 4'd5;
    #1;
    chk("mfhi_after_mult", bus.MDUout, 32'hFFFFFFFF);
    idle();

    run_op(4'd4, 32'd7, 32'd2, 1'b0, "divu_busy_len", 10);
    chk("divu_lo", bus.LO_out, 32'd3);
    chk("divu_hi", bus.HI_out, 32'd1);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div_busy_len", 10);
    chk("div_neg_lo", bus.LO_out, 32'hFFFFFFFD);
    chk("div_neg_hi", bus.HI_out, 32'hFFFFFFFF);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf_busy_len", 10);
    chk("div_ovf_lo", bus.LO_out, 32'h80000000);
    chk("div_ovf_hi", bus.HI_out, 32'h00000000);

    move(4'd7, 32'h12345678, 1'b0);
    move(4'd8, 32'h9ABCDEF0, 1'b0);
    chk("mthi", bus.HI_out, 32'h12345678);
    chk("mtlo", bus.LO_out, 32'h9ABCDEF0);
    move(4'd7, 32'hDEADBEEF, 1'b1);
    chk("mthi_req_blocked", bus.HI_out, 32'h12345678);

    // mult 2*3 in flight: mthi must be ignored and mflo must read the stale LO
    bus.MDUop = 4'd1; bus.MDUstart = 1'b1; bus.A = 32'd2; bus.B = 32'd3;
    cyc();
    idle();
    move(4'd7, 32'hCAFEF00D, 1'b0);
    chk("mthi_busy_blocked", bus.HI_out, 32'h12345678);
    bus.MDUop = 4'd6;
    #1;
    chk("mflo_stale", bus.MDUout, 32'h9ABCDEF0);
    cnt = 0;
    while (bus.busy && cnt < 64) begin
      cnt++;
      cyc();
    end
    chk("mflo_new", bus.MDUout, 32'd6);
    chk("mult_small_hi", bus.HI_out, 32'd0);
    idle();

    run_op(4'd2, 32'd10, 32'd10, 1'b1, "multu_req_busy_len", 0);
    chk("multu_req_hi", bus.HI_out, 32'd0);
    chk("multu_req_lo", bus.LO_out, 32'd6);

    move(4'd7, 32'h11111111, 1'b0);
    run_op(4'd3, 32'd5, 32'd0, 1'b0, "divzero_busy_len", 10);
    chk("divzero_hi", bus.HI_out, 32'h11111111);
    chk("divzero_lo", bus.LO_out, 32'd6);

    run_op(4'd1, 32'd3, 32'd4, 1'b0, "b2b_first_len", 5);
    chk("b2b_first_lo", bus.LO_out, 32'd12);
    run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "b2b_second_len", 5);
    chk("b2b_second_lo", bus.LO_out, 32'd1);
    chk("b2b_second_hi", bus.HI_out, 32'd0);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_busy_len", 5);
    chk("multu_hi", bus.HI_out, 32'hFFFFFFFE);
    chk("multu_lo", bus.LO_out, 32'h00000001);

    bus.MDUop = 4'd9;
    bus.A     = 32'h55555555;
    cyc();
    chk("op9_mduout", bus.MDUout, 32'd0);
    chk("op9_hi", bus.HI_out, 32'hFFFFFFFE);
    idle();

    // asynchronous reset between edges while a mult is in flight
    bus.MDUop = 4'd1; bus.MDUstart = 1'b1; bus.A = 32'd7; bus.B = 32'd6;
    cyc();
    idle();
    cyc();
    cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_hi", bus.HI_out, 32'd0);
    chk("rst_mid_lo", bus.LO_out, 32'd0);
    reset = 1'b1;
    repeat (8) cyc();
    chk("rst_late_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_late_hi", bus.HI_out, 32'd0);
    chk("rst_late_lo", bus.LO_out, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu start requests and mthi/mtlo/mfhi/mflo ops issued by the decoder, and holds the architectural HI/LO registers.
- Exposes busy to the hazard unit, which stalls the next MDU-class instruction in D.
- Honours the exception request so that a faulting or interrupted instruction never commits MDU state.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
MDUop  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
MDUstart  input  1  high with MDUop 1..4 for the one E-stage cycle of a md instruction
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
req  input  1  exception/interrupt taken this cycle; blocks all commits
busy  output  1  calculation in progress
HI_out  output  32  current HI register
LO_out  output  32  current LO register
MDUout  output  32  HI if MDUop=5, LO if MDUop=6, else 0 (combinational)

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, counter=0, pending regs=0, busy=0. An in-flight operation is discarded and HI/LO are not updated.
- States:
  - IDLE: counter=0.
  - CALC: counter>0.
  - busy = (counter != 0). busy is a registered-state decode; it has no combinational path from MDUstart.
- Start, taken at the rising edge when state is IDLE, MDUstart=1, MDUop in 1..4 and req=0:
  - Compute the 64-bit result from the A/B values sampled at that edge into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - busy is 1 for exactly N cycles following the start edge.
- CALC: counter decrements each edge. On the 1->0 edge, HI<=pending_hi and LO<=pending_lo. The new HI/LO are visible on HI_out/LO_out/MDUout from the cycle busy falls.
- MDUstart while busy: ignored. The hazard unit guarantees this does not occur; the verification bench asserts it.
- mthi/mtlo (ops 7/8) with req=0 and busy=0: HI<=A or LO<=A at the edge. Ignored when busy or req.
- mfhi/mflo: pure read via MDUout. Returns stale HI/LO while busy (hazard unit must stall).
- req=1: blocks start and mthi/mtlo in that cycle only. An operation already in CALC keeps running and completes.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 -> 64; HI=[63:32], LO=[31:0].
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div/divu): the operation still runs its full DIV_CYCLES and busy behaves normally, but HI/LO remain unchanged at completion.
- MDUop 0 or 9..15: no state change; MDUout=0.

Test Plan:
- Signed mult: reset released, A=0xFFFFFFFE (-2), B=3, MDUop=1, start pulse -> busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MDUop=5 gives MDUout=0xFFFFFFFF.
- Unsigned divide: divu A=7, B=2 -> busy 10 cycles, then LO=3, HI=1. Signed div A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Move-to registers: mthi A=0x12345678 then mtlo A=0x9ABCDEF0, each with busy=0 -> HI_out=0x12345678, LO_out=0x9ABCDEF0. Repeat mthi with req=1 -> HI unchanged. Repeat mthi while busy -> HI unchanged.
- Blocked start: multu with req=1 on the start cycle -> busy stays 0, HI/LO unchanged. Divide by zero: div A=5, B=0 -> busy 10 cycles, HI/LO keep prior values.
- Reset mid-operation: start mult, assert reset=0 asynchronously at cycle 3 between edges -> busy=0, HI=LO=0 immediately. After release, no late HI/LO write occurs.
- Back-to-back: second mult issued on the cycle busy falls after the first -> accepted. Stale read: mflo during busy returns the old LO; after completion returns the new LO.
